rs232_loader: RTL

Serial boot loader that is the receiving end of the host download stream. It sits between the board's RS232 RxD/TxD pins and the instruction memory write port, and is active while the core is held in reset. It decodes a framed word stream from the host and writes each word to memory. When the frame ends, it checks the checksum and sends one ACK or NAK byte back to the host over TxD.

---
 rtl/rs232_loader.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs232_loader.sv
// rs232_loader: serial boot loader, receiving end of the host download stream.
// Decodes the frame A5, cntLo, cntHi, N x 4 data bytes (little-endian words), sum.
// Each completed word is written to instruction memory. The loader then answers
// with one ACK (0x06) or NAK (0x15) byte on TxD.
//
// Ports:
//   clock    system clock, all logic on posedge
//   reset    synchronous, active-high
//   RxD      serial input (idle high, asynchronous to clock)
//   TxD      serial output (idle high)
//   wEn      one-cycle memory write strobe
//   wAddr    word address for wEn (10 bits)
//   wData    word data for wEn (32 bits)
//   loading  high from sync accepted until the response stop bit ends
//   done     high after an ACK is sent, cleared by the next sync byte
//   error    high after a NAK is sent, cleared by the next sync byte
module rs232_loader #(
  parameter int bitTime = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RxD,
  output logic        TxD,
  output logic        wEn,
  output logic [9:0]  wAddr,
  output logic [31:0] wData,
  output logic        loading,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(bitTime + 1);
  localparam logic [CW-1:0] BIT_CNT  = CW'(bitTime);
  localparam logic [CW-1:0] HALF_CNT = CW'(bitTime / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;
  localparam logic [7:0]    ACK_BYTE  = 8'h06;
  localparam logic [7:0]    NAK_BYTE  = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_WAIT} rxState_t;
  typedef enum logic [2:0] {ST_IDLE, ST_CNTLO, ST_CNTHI, ST_DATA, ST_SUM, ST_RESP} loadState_t;

  // ---------------- receiver ----------------
  logic          rxMeta_r, rxSync_r, rxPrev_r;
  rxState_t      rxState_r, rxNext_s;
  logic [CW-1:0] rxCnt_r, rxTarget_s;
  logic [3:0]    rxBit_r;
  logic [7:0]    rxShift_r;
  logic          rxValid_r, rxFrameErr_r;
  logic          rxSample_s, rxStart_s;

  // Receiver state register.
  always_ff @(posedge clock) begin
    if (reset) rxState_r <= RX_IDLE;
    else       rxState_r <= rxNext_s;
  end

  // Receiver next state: rxBit_r 0 is the start bit, 1..8 data, 9 stop.
  always_comb begin
    rxNext_s   = rxState_r;
    rxSample_s = 1'b0;
    rxStart_s  = 1'b0;
    rxTarget_s = (rxBit_r == 4'd0) ? HALF_CNT : BIT_CNT;
    case (rxState_r)
      RX_IDLE: begin
        if (!rxSync_r && rxPrev_r) begin
          rxStart_s = 1'b1;
          rxNext_s  = RX_BUSY;
        end else begin
          rxNext_s = RX_IDLE;
        end
      end
      RX_BUSY: begin
        if (rxCnt_r == rxTarget_s) begin
          rxSample_s = 1'b1;
          if (rxBit_r == 4'd0 && rxSync_r) begin
            rxNext_s = RX_IDLE;                 // start bit was a glitch
          end else if (rxBit_r == 4'd9) begin
            rxNext_s = rxSync_r ? RX_IDLE : RX_WAIT;
          end else begin
            rxNext_s = RX_BUSY;
          end
        end else begin
          rxNext_s = RX_BUSY;
        end
      end
      RX_WAIT: begin
        if (rxSync_r) rxNext_s = RX_IDLE;
        else          rxNext_s = RX_WAIT;
      end
      default: rxNext_s = RX_IDLE;
    endcase
  end

  // Receiver datapath: synchronizer, bit timing, shift register, byte strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta_r     <= 1'b1;
      rxSync_r     <= 1'b1;
      rxPrev_r     <= 1'b1;
      rxCnt_r      <= '0;
      rxBit_r      <= 4'd0;
      rxShift_r    <= 8'h00;
      rxValid_r    <= 1'b0;
      rxFrameErr_r <= 1'b0;
    end else begin
      rxMeta_r     <= RxD;
      rxSync_r     <= rxMeta_r;
      rxPrev_r     <= rxSync_r;
      rxValid_r    <= 1'b0;
      rxFrameErr_r <= 1'b0;
      if (rxStart_s) begin
        // The edge cycle counts as 0, so the next cycle is count 1.
        rxCnt_r <= CNT_ONE;
        rxBit_r <= 4'd0;
      end else if (rxSample_s) begin
        rxCnt_r <= CNT_ONE;
        rxBit_r <= rxBit_r + 4'd1;
        if (rxBit_r == 4'd9) begin
          rxValid_r    <= rxSync_r;
          rxFrameErr_r <= !rxSync_r;
        end else if (rxBit_r != 4'd0) begin
          rxShift_r <= {rxSync_r, rxShift_r[7:1]};
        end
      end else if (rxState_r == RX_BUSY) begin
        rxCnt_r <= rxCnt_r + CNT_ONE;
      end
    end
  end

  // ---------------- frame FSM ----------------
  loadState_t  state_r, nextState_s;
  logic [7:0]  sum_r;
  logic [9:0]  nWords_r, wordIdx_r, wAddr_r;
  logic [1:0]  byteIdx_r;
  logic [31:0] wData_r;
  logic        wEn_r, loading_r, done_r, error_r, respAck_r, txStart_r;
  logic        startFrame_s, takeByte_s, wordDone_s, respStart_s, respAck_s, respEnd_s;
  logic        txLast_s;

  // Frame state register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= nextState_s;
  end

  // Frame next state and per-byte strobes.
  always_comb begin
    nextState_s  = state_r;
    startFrame_s = 1'b0;
    takeByte_s   = 1'b0;
    wordDone_s   = 1'b0;
    respStart_s  = 1'b0;
    respAck_s    = 1'b0;
    respEnd_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rxValid_r && rxShift_r == SYNC_BYTE) begin
          startFrame_s = 1'b1;
          nextState_s  = ST_CNTLO;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_CNTLO, ST_CNTHI, ST_DATA: begin
        if (rxFrameErr_r) begin
          respStart_s = 1'b1;
          nextState_s = ST_RESP;
        end else if (rxValid_r) begin
          takeByte_s = 1'b1;
          if (state_r == ST_CNTLO) begin
            nextState_s = ST_CNTHI;
          end else if (state_r == ST_CNTHI) begin
            nextState_s = ST_DATA;
          end else if (byteIdx_r == 2'd3) begin
            wordDone_s = 1'b1;
            // N = 0 encodes 1024 words; the 10-bit subtract wraps to 1023.
            if (wordIdx_r == nWords_r - 10'd1) nextState_s = ST_SUM;
            else                               nextState_s = ST_DATA;
          end else begin
            nextState_s = ST_DATA;
          end
        end else begin
          nextState_s = state_r;
        end
      end
      ST_SUM: begin
        if (rxFrameErr_r) begin
          respStart_s = 1'b1;
          nextState_s = ST_RESP;
        end else if (rxValid_r) begin
          respStart_s = 1'b1;
          respAck_s   = (rxShift_r == sum_r);
          nextState_s = ST_RESP;
        end else begin
          nextState_s = ST_SUM;
        end
      end
      ST_RESP: begin
        if (txLast_s) begin
          respEnd_s   = 1'b1;
          nextState_s = ST_IDLE;
        end else begin
          nextState_s = ST_RESP;
        end
      end
      default: nextState_s = ST_IDLE;
    endcase
  end

  // Frame datapath: count, running sum, word assembly, write port, status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_r     <= 8'h00;
      nWords_r  <= 10'd0;
      wordIdx_r <= 10'd0;
      byteIdx_r <= 2'd0;
      wAddr_r   <= 10'd0;
      wData_r   <= 32'h0000_0000;
      wEn_r     <= 1'b0;
      loading_r <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      respAck_r <= 1'b0;
      txStart_r <= 1'b0;
    end else begin
      wEn_r     <= 1'b0;
      txStart_r <= 1'b0;
      if (wEn_r) wAddr_r <= wAddr_r + 10'd1;
      if (takeByte_s) begin
        sum_r <= sum_r + rxShift_r;
        case (state_r)
          ST_CNTLO: nWords_r[7:0] <= rxShift_r;
          ST_CNTHI: nWords_r[9:8] <= rxShift_r[1:0];
          ST_DATA: begin
            wData_r   <= {rxShift_r, wData_r[31:8]};
            byteIdx_r <= byteIdx_r + 2'd1;
          end
          default: sum_r <= sum_r + rxShift_r;
        endcase
      end
      if (wordDone_s) begin
        wEn_r     <= 1'b1;
        wordIdx_r <= wordIdx_r + 10'd1;
      end
      if (startFrame_s) begin
        loading_r <= 1'b1;
        done_r    <= 1'b0;
        error_r   <= 1'b0;
        wAddr_r   <= 10'd0;
        sum_r     <= 8'h00;
        wordIdx_r <= 10'd0;
        byteIdx_r <= 2'd0;
      end
      if (respStart_s) begin
        txStart_r <= 1'b1;
        respAck_r <= respAck_s;
      end
      if (respEnd_s) begin
        loading_r <= 1'b0;
        done_r    <= respAck_r;
        error_r   <= !respAck_r;
      end
    end
  end

  // ---------------- transmitter ----------------
  logic          txLine_r, txBusy_r;
  logic [CW-1:0] txCnt_r;
  logic [3:0]    txBit_r;
  logic [8:0]    txShift_r;

  assign txLast_s = txBusy_r && (txBit_r == 4'd9) && (txCnt_r == BIT_CNT);

  // Transmitter: start bit on the cycle after txStart_r, each bit BIT_CNT cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      txLine_r  <= 1'b1;
      txBusy_r  <= 1'b0;
      txCnt_r   <= '0;
      txBit_r   <= 4'd0;
      txShift_r <= 9'h1FF;
    end else if (txStart_r) begin
      txLine_r  <= 1'b0;
      txBusy_r  <= 1'b1;
      txCnt_r   <= CNT_ONE;
      txBit_r   <= 4'd0;
      // The trailing 1 shifts out as the stop bit.
      txShift_r <= {1'b1, (respAck_r ? ACK_BYTE : NAK_BYTE)};
    end else if (txBusy_r) begin
      if (txCnt_r == BIT_CNT) begin
        txCnt_r <= CNT_ONE;
        if (txBit_r == 4'd9) begin
          txBusy_r <= 1'b0;
          txLine_r <= 1'b1;
        end else begin
          txLine_r  <= txShift_r[0];
          txShift_r <= {1'b1, txShift_r[8:1]};
          txBit_r   <= txBit_r + 4'd1;
        end
      end else begin
        txCnt_r <= txCnt_r + CNT_ONE;
      end
    end else begin
      txLine_r <= 1'b1;
    end
  end

  assign TxD     = txLine_r;
  assign wEn     = wEn_r;
  assign wAddr   = wAddr_r;
  assign wData   = wData_r;
  assign loading = loading_r;
  assign done    = done_r;
  assign error   = error_r;

endmodule
